// File: rtl/poly_wave_pkg.sv
// Shared waveform definitions for the multi-voice oscillator and its wave shaper.
// Form codes above FORM_PULSE are reserved and shape to silence.
package poly_wave_pkg;

    typedef enum logic [2:0] {
        FORM_SAW    = 3'b000,
        FORM_REVSAW = 3'b001,
        FORM_TRIAN  = 3'b010,
        FORM_SQUARE = 3'b011,
        FORM_PULSE  = 3'b100
    } form_e;

    localparam int PW_W   = 7;
    localparam int FORM_W = 3;

endpackage

// File: rtl/wave_shaper.sv
// Combinational shaper: the top OUT_W phase bits -> one signed sample (offset binary flipped to two's complement).
// Disabled voices and reserved forms yield exactly zero.
module wave_shaper
    import poly_wave_pkg::*;
#(
    parameter int OUT_W = 16
) (
    input  logic [OUT_W-1:0]        phase_i,
    input  logic [FORM_W-1:0]       form_i,
    input  logic [PW_W-1:0]         pw_i,
    input  logic                    en_i,
    output logic signed [OUT_W-1:0] sample_o
);

    logic [OUT_W-1:0] u;
    logic [OUT_W-1:0] tri_q;
    logic             form_ok;

    always_comb begin
        tri_q   = phase_i << 1;
        u       = '0;
        form_ok = 1'b1;
        case (form_i)
            FORM_SAW:    u = phase_i;
            FORM_REVSAW: u = ~phase_i;
            FORM_TRIAN:  u = phase_i[OUT_W-1] ? ~tri_q : tri_q;
            FORM_SQUARE: u = {OUT_W{phase_i[OUT_W-1]}};
            // Pulse compares only the top PW_W phase bits, so pw=0 never fires.
            FORM_PULSE:  u = (phase_i[OUT_W-1 -: PW_W] < pw_i) ? '1 : '0;
            default:     form_ok = 1'b0;
        endcase
        sample_o = (en_i && form_ok) ? {~u[OUT_W-1], u[OUT_W-2:0]} : '0;
    end

endmodule

// File: rtl/poly_form_wave.sv
// Time-multiplexed VOICES-voice oscillator: one voice per clock, round-robin,
// summed into a signed mixed sample once per frame of VOICES clocks.
module poly_form_wave
    import poly_wave_pkg::*;
#(
    parameter  int VOICES  = 4,
    parameter  int PHASE_W = 32,
    parameter  int OUT_W   = 16,
    localparam int MIX_W   = OUT_W + $clog2(VOICES)
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    cfg_we,
    input  logic [3:0]              cfg_voice,
    input  logic [PHASE_W-1:0]      cfg_adder,
    input  logic [FORM_W-1:0]       cfg_form,
    input  logic [PW_W-1:0]         cfg_pw,
    input  logic                    cfg_en,
    input  logic                    cfg_sync,
    output logic signed [MIX_W-1:0] mix_out,
    output logic                    mix_valid
);

    localparam int SLOT_W = $clog2(VOICES);

    logic [SLOT_W-1:0]       slot_q, slot_d;
    logic signed [MIX_W-1:0] acc_q, acc_d;
    logic signed [MIX_W-1:0] mix_q, mix_d;
    logic                    valid_q, valid_d;
    logic                    frame_end;

    logic [OUT_W-1:0]  phase_top_arr [VOICES];
    logic [FORM_W-1:0] form_arr      [VOICES];
    logic [PW_W-1:0]   pw_arr        [VOICES];
    logic [VOICES-1:0] en_vec;

    logic signed [OUT_W-1:0] sample;
    logic signed [MIX_W-1:0] sample_ext;

    // Per-voice state. Writes hitting the active slot take effect next frame
    // because shaping and increment both read the registered (old) values.
    for (genvar gi = 0; gi < VOICES; gi++) begin : g_voice
        logic [PHASE_W-1:0] phase_q, phase_d;
        logic [PHASE_W-1:0] adder_q;
        logic [FORM_W-1:0]  form_q;
        logic [PW_W-1:0]    pw_q;
        logic               en_q;
        logic               cfg_hit;
        logic               slot_hit;

        assign cfg_hit  = cfg_we && (cfg_voice == 4'(gi));
        assign slot_hit = (slot_q == SLOT_W'(gi));

        always_comb begin
            phase_d = phase_q;
            if (cfg_hit && cfg_sync) begin
                phase_d = '0;
            end else if (slot_hit && en_q) begin
                phase_d = phase_q + adder_q;
            end
        end

        always_ff @(posedge CLK) begin
            if (RESET) begin
                phase_q <= '0;
                adder_q <= '0;
                form_q  <= '0;
                pw_q    <= '0;
                en_q    <= 1'b0;
            end else begin
                phase_q <= phase_d;
                if (cfg_hit) begin
                    adder_q <= cfg_adder;
                    form_q  <= cfg_form;
                    pw_q    <= cfg_pw;
                    en_q    <= cfg_en;
                end
            end
        end

        assign phase_top_arr[gi] = phase_q[PHASE_W-1 -: OUT_W];
        assign form_arr[gi]      = form_q;
        assign pw_arr[gi]        = pw_q;
        assign en_vec[gi]        = en_q;
    end

    wave_shaper #(
        .OUT_W (OUT_W)
    ) u_shaper (
        .phase_i  (phase_top_arr[slot_q]),
        .form_i   (form_arr[slot_q]),
        .pw_i     (pw_arr[slot_q]),
        .en_i     (en_vec[slot_q]),
        .sample_o (sample)
    );

    assign sample_ext = {{(MIX_W-OUT_W){sample[OUT_W-1]}}, sample};
    assign frame_end  = (slot_q == SLOT_W'(VOICES-1));

    always_comb begin
        slot_d  = frame_end ? '0 : slot_q + 1'b1;
        acc_d   = frame_end ? '0 : acc_q + sample_ext;
        mix_d   = frame_end ? acc_q + sample_ext : mix_q;
        valid_d = frame_end;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            slot_q  <= '0;
            acc_q   <= '0;
            mix_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            slot_q  <= slot_d;
            acc_q   <= acc_d;
            mix_q   <= mix_d;
            valid_q <= valid_d;
        end
    end

    assign mix_out   = mix_q;
    assign mix_valid = valid_q;

endmodule

// File: tb/tb_poly_form_wave.sv
// Self-checking bench for poly_form_wave: directed waveform scenarios plus
// randomized config traffic, all checked against an arithmetic voice model.
module tb_poly_form_wave;

    localparam int VOICES  = 4;
    localparam int PHASE_W = 32;
    localparam int OUT_W   = 16;
    localparam int MIX_W   = OUT_W + $clog2(VOICES);

    logic                    clk = 1'b0;
    logic                    srst = 1'b1;
    logic                    cfg_we = 1'b0;
    logic [3:0]              cfg_voice = '0;
    logic [PHASE_W-1:0]      cfg_adder = '0;
    logic [2:0]              cfg_form = '0;
    logic [6:0]              cfg_pw = '0;
    logic                    cfg_en = 1'b0;
    logic                    cfg_sync = 1'b0;
    logic signed [MIX_W-1:0] mix_out;
    logic                    mix_valid;

    always #5 clk = ~clk;

    poly_form_wave #(
        .VOICES  (VOICES),
        .PHASE_W (PHASE_W),
        .OUT_W   (OUT_W)
    ) dut (
        .CLK       (clk),
        .RESET     (srst),
        .cfg_we    (cfg_we),
        .cfg_voice (cfg_voice),
        .cfg_adder (cfg_adder),
        .cfg_form  (cfg_form),
        .cfg_pw    (cfg_pw),
        .cfg_en    (cfg_en),
        .cfg_sync  (cfg_sync),
        .mix_out   (mix_out),
        .mix_valid (mix_valid)
    );

    // Reference model state
    bit [31:0] m_phase [VOICES];
    bit [31:0] m_adder [VOICES];
    bit [2:0]  m_form  [VOICES];
    bit [6:0]  m_pw    [VOICES];
    bit        m_en    [VOICES];
    int        m_slot;
    longint    m_acc;
    longint    m_mix;
    bit        m_valid;

    int n_checks = 0;
    int n_errors = 0;
    int n_frames = 0;

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Signed sample of one voice, from the waveform definitions directly.
    function automatic int shape(bit [31:0] ph, bit [2:0] f, bit [6:0] pw, bit en);
        int p;
        int u;
        p = int'(ph >> 16);
        u = 0;
        if (!en || f > 3'd4) return 0;
        case (f)
            3'd0: u = p;
            3'd1: u = 65535 - p;
            3'd2: u = (p < 32768) ? 2 * p : 65535 - 2 * (p - 32768);
            3'd3: u = (p >= 32768) ? 65535 : 0;
            default: u = (int'(ph >> 25) < int'(pw)) ? 65535 : 0;
        endcase
        return u - 32768;
    endfunction

    task automatic tick();
        int s;
        @(posedge clk);
        if (srst) begin
            for (int v = 0; v < VOICES; v++) begin
                m_phase[v] = 0; m_adder[v] = 0; m_form[v] = 0; m_pw[v] = 0; m_en[v] = 0;
            end
            m_slot = 0; m_acc = 0; m_mix = 0; m_valid = 0;
        end else begin
            s = shape(m_phase[m_slot], m_form[m_slot], m_pw[m_slot], m_en[m_slot]);
            if (m_slot == VOICES - 1) begin
                m_mix = m_acc + s; m_acc = 0; m_valid = 1;
            end else begin
                m_acc += s; m_valid = 0;
            end
            if (m_en[m_slot]) m_phase[m_slot] += m_adder[m_slot];
            if (cfg_we && int'(cfg_voice) < VOICES) begin
                m_adder[cfg_voice] = cfg_adder;
                m_form[cfg_voice]  = cfg_form;
                m_pw[cfg_voice]    = cfg_pw;
                m_en[cfg_voice]    = cfg_en;
                if (cfg_sync) m_phase[cfg_voice] = 0;
            end
            m_slot = (m_slot + 1) % VOICES;
        end
        #1;
        check("valid", mix_valid, m_valid);
        check("mix", mix_out, m_mix);
        if (m_valid) begin
            n_frames++;
            $display("frame %0d mix_out=%0d model=%0d", n_frames, mix_out, m_mix);
        end
        cfg_we   = 1'b0;
        cfg_sync = 1'b0;
    endtask

    task automatic cfg_write(input int v, input logic [31:0] add, input int f,
                             input int pw, input bit en, input bit sync);
        cfg_we    = 1'b1;
        cfg_voice = 4'(v);
        cfg_adder = add;
        cfg_form  = 3'(f);
        cfg_pw    = 7'(pw);
        cfg_en    = en;
        cfg_sync  = sync;
        tick();
    endtask

    task automatic do_reset();
        srst = 1'b1;
        repeat (5) tick();
        srst = 1'b0;
    endtask

    task automatic wait_frame(output longint val);
        bit got;
        got = 1'b0;
        val = 0;
        for (int i = 0; i < 2 * VOICES && !got; i++) begin
            tick();
            if (mix_valid === 1'b1) begin
                got = 1'b1;
                val = longint'(mix_out);
            end
        end
        if (!got) check("frame_timeout", got, 1);
    endtask

    initial begin
        longint v;
        int     u;

        // Idle after reset: strobe on the 4th edge, silence throughout
        do_reset();
        for (int i = 1; i <= VOICES; i++) begin
            tick();
            check("first_strobe", mix_valid, i == VOICES);
        end
        check("idle_mix", mix_out, 0);
        for (int i = 0; i < 3; i++) begin
            wait_frame(v);
            check("idle_mix", v, 0);
        end

        // Saw on voice 0
        do_reset();
        cfg_write(0, 32'h1000_0000, 0, 0, 1, 1);
        wait_frame(v);
        check("saw_f0", v, 0);
        for (int i = 0; i < 17; i++) begin
            wait_frame(v);
            check("saw", v, -32768 + 4096 * (i % 16));
        end

        // Square then pulse on voice 1
        do_reset();
        cfg_write(1, 32'h1000_0000, 3, 0, 1, 1);
        for (int i = 0; i < 16; i++) begin
            wait_frame(v);
            check("square", v, (i < 8) ? -32768 : 32767);
        end
        do_reset();
        cfg_write(1, 32'h1000_0000, 4, 32, 1, 1);
        for (int i = 0; i < 16; i++) begin
            wait_frame(v);
            check("pulse", v, (i < 4) ? 32767 : -32768);
        end

        // All voices square in phase: full-scale mix extremes
        do_reset();
        for (int k = 0; k < VOICES; k++) cfg_write(k, 32'h8000_0000, 3, 0, 1, 1);
        wait_frame(v);
        check("mix_min", v, -131072);
        wait_frame(v);
        check("mix_max", v, 131068);

        // Triangle on voice 0
        do_reset();
        cfg_write(0, 32'h1000_0000, 2, 0, 1, 1);
        wait_frame(v);
        for (int i = 0; i < 16; i++) begin
            wait_frame(v);
            u = (i < 8) ? 8192 * i : 65535 - 8192 * (i - 8);
            check("triangle", v, u - 32768);
        end

        // Write to the voice in its own slot: old adder this frame, new next frame
        do_reset();
        cfg_write(2, 32'h1000_0000, 0, 0, 1, 1);
        tick();
        cfg_write(2, 32'h4000_0000, 0, 0, 1, 0);
        wait_frame(v);
        check("inslot_f0", v, -32768);
        wait_frame(v);
        check("inslot_f1", v, -28672);
        wait_frame(v);
        check("inslot_f2", v, -12288);

        // Out-of-range voice index is ignored
        cfg_write(7, $urandom(), 3, 5, 1, 1);
        wait_frame(v);
        check("voice7_ignored", v, 4096);

        // Reset mid-frame discards partial frame and restarts at voice 0
        tick();
        tick();
        srst = 1'b1;
        tick();
        check("midreset_valid", mix_valid, 0);
        check("midreset_mix", mix_out, 0);
        srst = 1'b0;
        for (int i = 1; i <= VOICES; i++) begin
            tick();
            check("restart_strobe", mix_valid, i == VOICES);
        end

        // Randomized config traffic with occasional resets
        for (int i = 0; i < 800; i++) begin
            srst = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 3) == 0) begin
                cfg_we    = 1'b1;
                cfg_voice = 4'($urandom_range(0, 7));
                cfg_adder = $urandom_range(0, 1) ? $urandom() : 32'($urandom_range(0, 3)) << 28;
                cfg_form  = 3'($urandom_range(0, 7));
                cfg_pw    = 7'($urandom());
                cfg_en    = ($urandom_range(0, 3) != 0);
                cfg_sync  = ($urandom_range(0, 3) == 0);
            end
            tick();
        end
        srst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
